// File: rtl/axi_udp_pkg.sv
// ----------------------------------------------------------------------------
// axi_udp_pkg
// Shared types and constants for the ARP transmit scheduler.
//   ARP_OP_REQUEST / ARP_OP_REPLY : ARP opcodes placed on arp_opcode
//   MAC_BCAST                     : broadcast MAC used by announcements
//   sched_state_t                 : scheduler FSM state (also exported for debug)
//   arp_req_t                     : one queued reply target {mac, ip}
// ----------------------------------------------------------------------------
package axi_udp_pkg;

  localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
  localparam logic [47:0] MAC_BCAST      = 48'hffff_ffff_ffff;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_req_t;

endpackage

// File: rtl/axi_udp_arp_fifo.sv
// ----------------------------------------------------------------------------
// axi_udp_arp_fifo
// DEPTH-entry synchronous FIFO of arp_req_t holding pending ARP replies.
// Ports:
//   clk, aresetn : clock, asynchronous active-low reset (pointers/count only)
//   i_push       : write i_data (ignored when full)
//   i_data       : entry to write
//   i_pop        : drop the head entry (ignored when empty)
//   o_data       : head entry, valid whenever o_empty = 0
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module axi_udp_arp_fifo
  import axi_udp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     aresetn,
  input  logic     i_push,
  input  arp_req_t i_data,
  input  logic     i_pop,
  output arp_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  arp_req_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_udp_arp_sched.sv
// ----------------------------------------------------------------------------
// axi_udp_arp_sched
// Shares one ARP frame generator between queued replies, periodic gratuitous
// announcements and upper-layer queries. Issues one start pulse per frame,
// holds the frame arguments until the frame's last beat is accepted, then
// idles for GAP_CYCLES.
// Ports:
//   clk, aresetn                    : clock, asynchronous active-low reset
//   rpl_valid/rpl_ready/rpl_mac/ip  : reply request input (queued)
//   qry_valid/qry_ready/qry_ip      : query request input (not queued)
//   arp_start                       : one-cycle start pulse to the generator
//   arp_opcode/arp_dst_mac/arp_dst_ip : frame arguments, stable per frame
//   tx_tvalid/tx_tready/tx_tlast    : monitored generator output stream
//   busy                            : frame in flight or inter-frame gap
//   timeout_err                     : sticky frame-timeout flag
//   dbg_state                       : current scheduler state
// Handshakes: a request transfers on a rising clock edge where valid and
// ready are both 1. rpl_ready depends only on registers; qry_ready is high
// only in the idle cycle that selects the query and may depend on qry_valid.
// ----------------------------------------------------------------------------
module axi_udp_arp_sched
  import axi_udp_pkg::*;
#(
  parameter logic [15:0] IP_MSB          = 16'hc0a8,
  parameter logic [15:0] IP_LSB          = 16'h0602,
  parameter logic [31:0] ANNOUNCE_PERIOD = 32'd125000000,
  parameter logic [7:0]  GAP_CYCLES      = 8'd12,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd4096,
  parameter int          RPL_DEPTH       = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         rpl_valid,
  output logic         rpl_ready,
  input  logic [47:0]  rpl_mac,
  input  logic [31:0]  rpl_ip,
  input  logic         qry_valid,
  output logic         qry_ready,
  input  logic [31:0]  qry_ip,
  output logic         arp_start,
  output logic [15:0]  arp_opcode,
  output logic [47:0]  arp_dst_mac,
  output logic [31:0]  arp_dst_ip,
  input  logic         tx_tvalid,
  input  logic         tx_tready,
  input  logic         tx_tlast,
  output logic         busy,
  output logic         timeout_err,
  output sched_state_t dbg_state
);

  sched_state_t r_state;
  logic [15:0]  r_opcode;
  logic [47:0]  r_dst_mac;
  logic [31:0]  r_dst_ip;
  logic [15:0]  r_to_cnt;
  logic [7:0]   r_gap_cnt;
  logic         r_timeout_err;
  logic [31:0]  r_ann_cnt;
  logic         r_ann_pending;
  logic         r_run;

  arp_req_t     w_head;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic         w_push;
  logic         w_idle;
  logic         w_sel_rpl;
  logic         w_sel_ann;
  logic         w_sel_qry;
  logic         w_ann_tick;
  logic         w_last_beat;

  // Selection priority in idle: queued reply, pending announce, query.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_sel_rpl   = w_idle && !w_fifo_empty;
  assign w_sel_ann   = w_idle && w_fifo_empty && r_ann_pending;
  assign w_sel_qry   = w_idle && w_fifo_empty && !r_ann_pending && qry_valid;
  assign w_ann_tick  = (ANNOUNCE_PERIOD != 32'd0) &&
                       (r_ann_cnt == ANNOUNCE_PERIOD - 32'd1);
  assign w_last_beat = tx_tvalid && tx_tready && tx_tlast;

  // r_run keeps rpl_ready low while reset is held, so every output is 0 in reset.
  assign rpl_ready   = r_run && !w_fifo_full;
  assign w_push      = rpl_valid && rpl_ready;
  assign qry_ready   = w_sel_qry;
  assign arp_start   = (r_state == ST_START);
  assign busy        = !w_idle;
  assign arp_opcode  = r_opcode;
  assign arp_dst_mac = r_dst_mac;
  assign arp_dst_ip  = r_dst_ip;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

  axi_udp_arp_fifo #(
    .DEPTH (RPL_DEPTH)
  ) u_rpl_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .i_push  (w_push),
    .i_data  ({rpl_mac, rpl_ip}),
    .i_pop   (w_sel_rpl),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Announce timer. A tick in the same cycle an announce is selected re-arms
  // the flag, so that tick is not lost.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_ann_cnt     <= '0;
      r_ann_pending <= 1'b1;
      r_run         <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (ANNOUNCE_PERIOD != 32'd0) begin
        r_ann_cnt <= w_ann_tick ? 32'd0 : r_ann_cnt + 32'd1;
      end
      r_ann_pending <= w_ann_tick || (r_ann_pending && !w_sel_ann);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_opcode      <= '0;
      r_dst_mac     <= '0;
      r_dst_ip      <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_rpl) begin
            r_opcode  <= ARP_OP_REPLY;
            r_dst_mac <= w_head.mac;
            r_dst_ip  <= w_head.ip;
            r_state   <= ST_START;
          end else if (w_sel_ann) begin
            r_opcode  <= ARP_OP_REQUEST;
            r_dst_mac <= MAC_BCAST;
            r_dst_ip  <= {IP_MSB, IP_LSB};
            r_state   <= ST_START;
          end else if (w_sel_qry) begin
            r_opcode  <= ARP_OP_REQUEST;
            r_dst_mac <= '0;
            r_dst_ip  <= qry_ip;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A last beat in the final timeout cycle still counts as success.
          if (w_last_beat) begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else if (r_to_cnt == TIMEOUT_CYCLES - 16'd1) begin
            r_timeout_err <= 1'b1;
            r_gap_cnt     <= '0;
            r_state       <= ST_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if ((GAP_CYCLES == 8'd0) || (r_gap_cnt == GAP_CYCLES - 8'd1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_udp_arp_sched.sv
module tb_axi_udp_arp_sched;
  import axi_udp_pkg::*;

  localparam int PERIOD = 1000;
  localparam int GAP    = 12;
  localparam int TO     = 4096;
  localparam int DEPTH  = 4;
  localparam logic [31:0] OWN_IP = 32'hc0a8_0602;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic         rpl_valid = 1'b0;
  logic [47:0]  rpl_mac = '0;
  logic [31:0]  rpl_ip = '0;
  logic         qry_valid = 1'b0;
  logic [31:0]  qry_ip = '0;
  logic         tx_tvalid = 1'b0;
  logic         tx_tready = 1'b0;
  logic         tx_tlast = 1'b0;
  logic         rpl_ready;
  logic         qry_ready;
  logic         arp_start;
  logic [15:0]  arp_opcode;
  logic [47:0]  arp_dst_mac;
  logic [31:0]  arp_dst_ip;
  logic         busy;
  logic         timeout_err;
  sched_state_t dbg_state;

  axi_udp_arp_sched #(
    .ANNOUNCE_PERIOD (32'(PERIOD)),
    .GAP_CYCLES      (8'(GAP)),
    .TIMEOUT_CYCLES  (16'(TO)),
    .RPL_DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .rpl_valid   (rpl_valid),
    .rpl_ready   (rpl_ready),
    .rpl_mac     (rpl_mac),
    .rpl_ip      (rpl_ip),
    .qry_valid   (qry_valid),
    .qry_ready   (qry_ready),
    .qry_ip      (qry_ip),
    .arp_start   (arp_start),
    .arp_opcode  (arp_opcode),
    .arp_dst_mac (arp_dst_mac),
    .arp_dst_ip  (arp_dst_ip),
    .tx_tvalid   (tx_tvalid),
    .tx_tready   (tx_tready),
    .tx_tlast    (tx_tlast),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending replies as a plain queue; the frame in flight is described by
  // "start pulse due", "waiting for last beat" and "gap cycles remaining".
  arp_req_t    exp_q[$];
  bit          m_ann, m_run, m_start, m_waiting, m_err;
  int          m_wait_cnt, m_gap_left, m_ann_cnt;
  logic [15:0] m_op;
  logic [47:0] m_mac;
  logic [31:0] m_ip;
  bit          s_push, s_tick, s_took_ann;
  arp_req_t    s_in, s_head;

  function automatic bit m_idle();
    return !m_start && !m_waiting && (m_gap_left == 0);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ann = 1'b1; m_run = 1'b0; m_start = 1'b0; m_waiting = 1'b0; m_err = 1'b0;
    m_wait_cnt = 0; m_gap_left = 0; m_ann_cnt = 0;
    m_op = '0; m_mac = '0; m_ip = '0;
  endtask

  task automatic model_step();
    s_push     = rpl_valid && m_run && (exp_q.size() < DEPTH);
    s_in       = {rpl_mac, rpl_ip};
    s_tick     = (m_ann_cnt == PERIOD - 1);
    s_took_ann = 1'b0;
    if (m_idle()) begin
      if (exp_q.size() > 0) begin
        s_head = exp_q.pop_front();
        m_op = 16'h0002; m_mac = s_head.mac; m_ip = s_head.ip; m_start = 1'b1;
      end else if (m_ann) begin
        m_op = 16'h0001; m_mac = 48'hffff_ffff_ffff; m_ip = OWN_IP; m_start = 1'b1;
        s_took_ann = 1'b1;
      end else if (qry_valid) begin
        m_op = 16'h0001; m_mac = 48'h0; m_ip = qry_ip; m_start = 1'b1;
      end
    end else if (m_start) begin
      m_start = 1'b0; m_waiting = 1'b1; m_wait_cnt = 0;
    end else if (m_waiting) begin
      if (tx_tvalid && tx_tready && tx_tlast) begin
        m_waiting = 1'b0; m_gap_left = (GAP == 0) ? 1 : GAP;
      end else if (m_wait_cnt == TO - 1) begin
        m_err = 1'b1; m_waiting = 1'b0; m_gap_left = (GAP == 0) ? 1 : GAP;
      end else begin
        m_wait_cnt++;
      end
    end else begin
      m_gap_left--;
    end
    if (s_push) exp_q.push_back(s_in);
    m_ann     = s_tick || (m_ann && !s_took_ann);
    m_ann_cnt = s_tick ? 0 : m_ann_cnt + 1;
    m_run     = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge aresetn);
      if (!aresetn) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process (every cycle) ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("arp_start",   arp_start,   aresetn && m_start);
      check("busy",        busy,        aresetn && !m_idle());
      check("arp_opcode",  arp_opcode,  aresetn ? m_op : 16'h0);
      check("arp_dst_mac", arp_dst_mac, aresetn ? m_mac : 48'h0);
      check("arp_dst_ip",  arp_dst_ip,  aresetn ? m_ip : 32'h0);
      check("timeout_err", timeout_err, aresetn && m_err);
      check("rpl_ready",   rpl_ready,   aresetn && m_run && (exp_q.size() < DEPTH));
      check("qry_ready",   qry_ready,   aresetn && m_idle() && (exp_q.size() == 0) && !m_ann && qry_valid);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic set_tx(input bit v, input bit r, input bit l);
    tx_tvalid = v; tx_tready = r; tx_tlast = l;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, arp_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_op"}, arp_opcode, 0);
    check({tag, "_mac"}, arp_dst_mac, 0);
    check({tag, "_ip"}, arp_dst_ip, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_rpl_ready"}, rpl_ready, 0);
    check({tag, "_qry_ready"}, qry_ready, 0);
  endtask

  task automatic check_announce(input string tag);
    check({tag, "_start"}, arp_start, 1);
    check({tag, "_op"}, arp_opcode, 16'h0001);
    check({tag, "_mac"}, arp_dst_mac, 48'hffff_ffff_ffff);
    check({tag, "_ip"}, arp_dst_ip, 32'hc0a8_0602);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] st_ip [4];
  logic [15:0] st_op [4];
  logic [47:0] st_mac[4];
  int          st_cyc[4];
  int          ns, cnt, qcnt;
  bit          clr, qr, seen;

  initial begin
    // Reset state and first announcement.
    repeat (3) step();
    check_all_zero("reset");
    aresetn = 1'b1;
    step();
    check_announce("first_ann");
    step();
    set_tx(1, 1, 1);
    step();
    set_tx(0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) cnt++;
      step();
    end
    check("gap_busy_cycles", cnt, 12);

    // Single reply, then a 5-deep burst against a 4-entry queue.
    rpl_valid = 1'b1; rpl_mac = 48'h0011_2233_4455; rpl_ip = 32'hc0a8_0605;
    step();
    rpl_valid = 1'b0;
    step();
    check("rpl_start", arp_start, 1);
    check("rpl_op", arp_opcode, 16'h0002);
    check("rpl_mac", arp_dst_mac, 48'h0011_2233_4455);
    check("rpl_ip", arp_dst_ip, 32'hc0a8_0605);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_ready_%0d", i), rpl_ready, (i < 4) ? 1 : 0);
      rpl_valid = 1'b1;
      rpl_mac = 48'h0a00_0000_0000 + 48'(i);
      rpl_ip = 32'hc0a8_0610 + 32'(i);
      step();
    end
    rpl_valid = 1'b0;
    check("rpl_hold_mac", arp_dst_mac, 48'h0011_2233_4455);
    check("rpl_hold_ip", arp_dst_ip, 32'hc0a8_0605);
    set_tx(1, 1, 1);
    ns = 0;
    for (int c = 0; c < 200 && ns < 4; c++) begin
      step();
      if (arp_start) begin
        st_ip[ns] = arp_dst_ip; st_cyc[ns] = c; ns++;
      end
    end
    check("burst_frames", ns, 4);
    for (int k = 0; k < 4; k++) check($sformatf("burst_ip_%0d", k), st_ip[k], 32'hc0a8_0610 + 32'(k));
    check("burst_spacing", st_cyc[1] - st_cyc[0], 15);
    repeat (20) step();

    // Reply + announce + query together: priority order.
    set_tx(0, 0, 0);
    rpl_valid = 1'b1; rpl_mac = 48'h0a0a_0a0a_0a0a; rpl_ip = 32'hc0a8_06a0;
    step();
    rpl_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1500 && !seen; c++) begin
      step();
      seen = m_ann && busy;
    end
    check("prio_ann_pending_seen", seen, 1);
    rpl_valid = 1'b1; rpl_mac = 48'h0b0b_0b0b_0b0b; rpl_ip = 32'hc0a8_06a1;
    qry_valid = 1'b1; qry_ip = 32'hc0a8_0699;
    set_tx(1, 1, 1);
    ns = 0; qcnt = 0; clr = 1'b0;
    for (int c = 0; c < 150; c++) begin
      step();
      rpl_valid = 1'b0;
      qr = qry_ready;
      if (qr) qcnt++;
      if (clr) qry_valid = 1'b0;
      clr = qr;
      if (arp_start && ns < 3) begin
        st_op[ns] = arp_opcode; st_mac[ns] = arp_dst_mac; st_ip[ns] = arp_dst_ip; ns++;
      end
    end
    check("prio_frames", ns, 3);
    check("prio_0_op", st_op[0], 16'h0002);
    check("prio_0_ip", st_ip[0], 32'hc0a8_06a1);
    check("prio_1_op", st_op[1], 16'h0001);
    check("prio_1_mac", st_mac[1], 48'hffff_ffff_ffff);
    check("prio_2_op", st_op[2], 16'h0001);
    check("prio_2_mac", st_mac[2], 48'h0);
    check("prio_2_ip", st_ip[2], 32'hc0a8_0699);
    check("qry_ready_pulses", qcnt, 1);

    // Randomized traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      step();
      rpl_valid = ($urandom_range(0, 3) == 0);
      rpl_mac   = {16'($urandom), 32'($urandom)};
      rpl_ip    = $urandom;
      qry_valid = ($urandom_range(0, 7) == 0);
      qry_ip    = $urandom;
      set_tx($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    rpl_valid = 1'b0; qry_valid = 1'b0;
    set_tx(1, 1, 1);
    repeat (100) step();

    // Timeout: hold tready low after a start.
    set_tx(0, 0, 0);
    qry_valid = 1'b1; qry_ip = 32'hc0a8_06ee;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      seen = arp_start;
    end
    check("to_start_seen", seen, 1);
    qry_valid = 1'b0;
    cnt = 0;
    while (!timeout_err && cnt < 5000) begin
      step();
      cnt++;
    end
    check("timeout_latency", cnt, 4097);
    check("timeout_err_set", timeout_err, 1);
    qry_valid = 1'b1; qry_ip = 32'hc0a8_06ef;
    set_tx(1, 1, 1);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      seen = qry_ready;
    end
    check("served_after_timeout", seen, 1);
    step();
    qry_valid = 1'b0;
    repeat (20) step();

    // Reset while waiting for the last beat.
    set_tx(0, 0, 0);
    qry_valid = 1'b1; qry_ip = 32'hc0a8_06bb;
    rpl_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      seen = arp_start;
    end
    check("mid_start_seen", seen, 1);
    qry_valid = 1'b0;
    rpl_valid = 1'b1; rpl_mac = 48'h0c0c_0c0c_0c0c; rpl_ip = 32'hc0a8_06cc;
    repeat (5) step();
    rpl_valid = 1'b0;
    @(negedge clk);
    #1 aresetn = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) step();
    aresetn = 1'b1;
    step();
    check_announce("post_reset_ann");
    set_tx(1, 1, 1);
    repeat (40) step();
    check("post_reset_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_udp_arp_sched.md
Name: axi_udp_arp_sched

Overview:
Scheduler in front of the ARP transmit datapath (arp_start / arp_opcode / arp_dst_mac / arp_dst_ip). It shares that single frame generator between three sources: ARP replies queued by the receive parser, ARP who-has queries from the upper layer, and a periodic gratuitous announcement. It issues one start pulse per frame and holds the frame arguments stable until the frame's last beat is accepted on the Ethernet stream. It then enforces an inter-frame gap.

Parameters:
IP_MSB, 16'hc0a8, upper half of the local IPv4 address; used as the announce target IP.
IP_LSB, 16'h0602, lower half of the local IPv4 address.
ANNOUNCE_PERIOD, 32'd125000000, cycles between gratuitous announcements; 0 disables announcements.
GAP_CYCLES, 8'd12, idle cycles after each frame before the next start.
TIMEOUT_CYCLES, 16'd4096, maximum cycles from start to observed last beat.
RPL_DEPTH, 4, reply queue depth; must be a power of two and at least 2.

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
rpl_valid  in  1  reply request valid
rpl_ready  out  1  reply queue not full
rpl_mac  in  48  requester MAC
rpl_ip  in  32  requester IP
qry_valid  in  1  query request valid
qry_ready  out  1  query accepted (single-cycle pulse)
qry_ip  in  32  IP to resolve
arp_start  out  1  one-cycle start pulse to the frame generator
arp_opcode  out  16  ARP opcode
arp_dst_mac  out  48  destination MAC
arp_dst_ip  out  32  destination IP
tx_tvalid  in  1  monitored tvalid of the generator's stream
tx_tready  in  1  monitored tready of the generator's stream
tx_tlast  in  1  monitored tlast of the generator's stream
busy  out  1  frame in flight or gap active
timeout_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (asynchronous, aresetn=0) drives every output to 0:
  - all FSM state, counters and queue pointers cleared;
  - announce counter cleared; announce_pending set to 1 so one announcement is sent first after reset.
- Reply queue:
  - push when rpl_valid && rpl_ready; rpl_ready = !full.
  - pop occurs in ST_IDLE when a reply is selected.
  - push and pop in the same cycle while full is not possible, because rpl_ready = 0.
  - push and pop in the same cycle otherwise: count is unchanged.
  - pointers wrap modulo RPL_DEPTH.
- Announce timer:
  - free-running counter; on reaching ANNOUNCE_PERIOD-1 it wraps to 0 and sets announce_pending.
  - if announce_pending is already set, the new event merges into it (no counting of missed announcements).
- FSM states: ST_IDLE, ST_START, ST_WAIT, ST_GAP.
  - ST_IDLE, selection priority: reply queue non-empty, then announce_pending, then qry_valid.
    - Reply: opcode 0x0002, dst = queue head MAC/IP; pop.
    - Announce: opcode 0x0001, dst_mac = 48'hffffffffffff, dst_ip = {IP_MSB,IP_LSB}; clear announce_pending.
    - Query: opcode 0x0001, dst_mac = 48'h000000000000, dst_ip = qry_ip; qry_ready pulses 1 for this cycle.
    - Arguments are registered in this cycle; go to ST_START.
  - ST_START:
    - arp_start = 1 for exactly this cycle;
    - clear the timeout counter; go to ST_WAIT.
  - ST_WAIT:
    - on tx_tvalid && tx_tready && tx_tlast, go to ST_GAP;
    - if the timeout counter reaches TIMEOUT_CYCLES-1 first, set timeout_err and go to ST_GAP;
    - beats without tlast are ignored.
  - ST_GAP:
    - count GAP_CYCLES cycles, then return to ST_IDLE;
    - GAP_CYCLES = 0 returns on the next cycle.
- arp_opcode / arp_dst_mac / arp_dst_ip change only on selection in ST_IDLE and hold through ST_START, ST_WAIT and ST_GAP.
- busy = 1 in ST_START, ST_WAIT and ST_GAP.
- Latency: request present in ST_IDLE → arp_start 2 cycles later (select cycle, then the ST_START register).
- Requests arriving during a frame wait; announce_pending and queued replies persist across frames.
- Reset mid-frame: return to ST_IDLE immediately; the queue is flushed; no further arp_start until reset is released and the selection cycle completes.

Decomposition:
- axi_udp_pkg:
  - ARP_OP_REQUEST = 16'h0001, ARP_OP_REPLY = 16'h0002, MAC_BCAST;
  - state enum sched_state_t;
  - packed struct arp_req_t {mac[47:0], ip[31:0]}.
- Sub-module axi_udp_arp_fifo: RPL_DEPTH-entry synchronous FIFO of arp_req_t with full/empty; same clk/aresetn.

Test Plan:
- Release reset with ANNOUNCE_PERIOD=1000 → after 2 cycles, arp_start pulse with opcode 0x0001, dst_mac ffffffffffff, dst_ip c0a80602; after a tlast handshake, busy stays 1 for 12 cycles, then 0.
- Push reply {mac 001122334455, ip c0a80605} while idle → arp_start 2 cycles later with opcode 0x0002 and those values; the values stay stable until tlast, even if a new reply is pushed meanwhile.
- Push 5 replies back-to-back with RPL_DEPTH=4 while a frame is in flight → rpl_ready = 0 after the 4th; all 4 are sent in order, each separated by a 12-cycle gap.
- Assert qry_valid (ip c0a80699) simultaneously with a queued reply and a pending announce → frame order is reply, announce, query; qry_ready pulses exactly once, in the query selection cycle.
- Hold tx_tready = 0 after arp_start → timeout_err = 1 at 4096 cycles; FSM proceeds through ST_GAP; the next request is still served.
- Deassert aresetn mid-ST_WAIT → all outputs 0 asynchronously; after release, the announce frame is sent first and the queue is empty.
